// File: rtl/gate_pkg.sv
// Shared constants and FSM state type for the gate_ctrl power-gating sequencer.
package gate_pkg;

    localparam int N_GATE_DEF = 5;
    localparam int CNT_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DOWN   = 3'd1,
        ST_UP     = 3'd2,
        ST_SETTLE = 3'd3,
        ST_ACKW   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

endpackage

// File: rtl/gate_tmr.sv
// Loadable down-counter with a zero flag; saturates at zero instead of wrapping.
module gate_tmr
    import gate_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_ctrl.sv
// Sequences domain clock-gate enables one bit at a time (downs high-to-low, then ups low-to-high).
// Optional GATE_CTRL_ACK_EN adds a per-step ack wait with timeout and a sticky err_o.
module gate_ctrl
    import gate_pkg::*;
#(
    parameter int N_GATE   = N_GATE_DEF,
    parameter int STEP_DLY = 1000,
    parameter int ACK_TMO  = 4096
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [N_GATE-1:0] req_mask_i,
    input  logic [N_GATE-1:0] ack_i,
    output logic [N_GATE-1:0] gate_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int IDX_W = (N_GATE > 1) ? $clog2(N_GATE) : 1;

    state_e             state_q;
    logic [N_GATE-1:0]  gate_q;
    logic [N_GATE-1:0]  target_q;
    logic [IDX_W-1:0]   idx_q;

    logic               accept;
    logic [N_GATE-1:0]  tgt;
    logic [N_GATE-1:0]  dn_bits;
    logic [N_GATE-1:0]  up_bits;
    logic [IDX_W-1:0]   dn_idx;
    logic [IDX_W-1:0]   up_idx;
    state_e             step_state;
    logic [IDX_W-1:0]   step_idx;
    logic [N_GATE-1:0]  step_gate;
    logic               settle_zero;

    assign accept = req_valid_i && (state_q == ST_IDLE);

    // Next step is decided against the live mask on accept, else against the latched target.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tgt        = (state_q == ST_IDLE) ? req_mask_i : target_q;
        dn_bits    = gate_q & ~tgt;
        up_bits    = ~gate_q & tgt;
        dn_idx     = '0;
        up_idx     = '0;
        for (int i = 0; i < N_GATE; i++) begin
            if (dn_bits[i]) dn_idx = IDX_W'(i);
        end
        for (int i = N_GATE - 1; i >= 0; i--) begin
            if (up_bits[i]) up_idx = IDX_W'(i);
        end
        step_state = ST_DONE;
        step_idx   = idx_q;
        step_gate  = gate_q;
        if (|dn_bits) begin
            step_state        = ST_DOWN;
            step_idx          = dn_idx;
            step_gate[dn_idx] = 1'b0;
        end else if (|up_bits) begin
            step_state        = ST_UP;
            step_idx          = up_idx;
            step_gate[up_idx] = 1'b1;
        end
    end

    gate_tmr #(.W(CNT_W)) u_settle_tmr (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     ((state_q == ST_DOWN) || (state_q == ST_UP)),
        .load_val_i (CNT_W'(STEP_DLY - 1)),
        .dec_i      (state_q == ST_SETTLE),
        .zero_o     (settle_zero)
    );

`ifdef GATE_CTRL_ACK_EN
    logic ack_zero;
    logic ack_ok;
    logic ack_tmo;
    logic err_q;

    assign ack_ok  = (ack_i[idx_q] == gate_q[idx_q]);
    assign ack_tmo = (state_q == ST_ACKW) && !ack_ok && ack_zero;

    gate_tmr #(.W(CNT_W)) u_ack_tmr (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     ((state_q == ST_SETTLE) && settle_zero),
        .load_val_i (CNT_W'(ACK_TMO - 1)),
        .dec_i      (state_q == ST_ACKW),
        .zero_o     (ack_zero)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (ack_tmo) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic unused_ack;
    assign unused_ack = ^{ack_i, idx_q, ACK_TMO[0]};
    assign err_o      = 1'b0;
`endif

    // The gate bit flips on the edge that enters DOWN/UP, so a change is visible the cycle after accept.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            gate_q   <= '0;
            target_q <= '0;
            idx_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        target_q <= req_mask_i;
                        state_q  <= step_state;
                        gate_q   <= step_gate;
                        idx_q    <= step_idx;
                    end
                end
                ST_DOWN, ST_UP: begin
                    state_q <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_zero) begin
`ifdef GATE_CTRL_ACK_EN
                        state_q <= ST_ACKW;
`else
                        state_q <= step_state;
                        gate_q  <= step_gate;
                        idx_q   <= step_idx;
`endif
                    end
                end
`ifdef GATE_CTRL_ACK_EN
                ST_ACKW: begin
                    if (ack_ok) begin
                        state_q <= step_state;
                        gate_q  <= step_gate;
                        idx_q   <= step_idx;
                    end else if (ack_zero) begin
                        state_q <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign gate_en_o   = gate_q;

endmodule

// File: tb/tb_gate_ctrl.sv
// Self-checking bench for gate_ctrl: directed sequences plus random masks against a timeline model.
module tb_gate_ctrl;

    localparam int NG       = 5;
    localparam int STEP_DLY = 4;
    localparam int ACK_TMO  = 8;
`ifdef GATE_CTRL_ACK_EN
    localparam int P = STEP_DLY + 2;
`else
    localparam int P = STEP_DLY + 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [NG-1:0] req_mask = '0;
    logic [NG-1:0] ack;
    logic [NG-1:0] ack_ok = '1;
    logic          req_ready;
    logic [NG-1:0] gate_en;
    logic          busy;
    logic          done;
    logic          err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [NG-1:0] cur_exp = '0;
    logic          err_exp = 1'b0;

    assign ack = gate_en & ack_ok;

    always #5 clk = ~clk;

    gate_ctrl #(
        .N_GATE   (NG),
        .STEP_DLY (STEP_DLY),
        .ACK_TMO  (ACK_TMO)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_mask_i  (req_mask),
        .ack_i       (ack),
        .gate_en_o   (gate_en),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        check({tag, ".busy"},  32'(busy),      32'd0);
        check({tag, ".done"},  32'(done),      32'd0);
        check({tag, ".gate"},  32'(gate_en),   32'(cur_exp));
        check({tag, ".err"},   32'(err),       32'(err_exp));
    endtask

    // Model: ordered list of bits to toggle; change k is visible at T+1+k*P, done at T+1+n*P.
    task automatic run_req(input logic [NG-1:0] mask, input bit noise);
        int            chg[$];
        int            n;
        int            last;
        int            k;
        logic [NG-1:0] v;
        for (int i = NG - 1; i >= 0; i--) if (cur_exp[i] && !mask[i]) chg.push_back(i);
        for (int i = 0; i < NG; i++)      if (!cur_exp[i] && mask[i]) chg.push_back(i);
        n    = chg.size();
        last = 1 + n * P;
        @(negedge clk);
        check_idle("pre");
        req_valid = 1'b1;
        req_mask  = mask;
        v         = cur_exp;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (((c - 1) % P == 0) && ((c - 1) / P < n)) begin
                k    = chg[(c - 1) / P];
                v[k] = ~v[k];
            end
            check("seq.gate",  32'(gate_en),   32'(v));
            check("seq.busy",  32'(busy),      32'd1);
            check("seq.ready", 32'(req_ready), 32'd0);
            check("seq.done",  32'(done),      32'(c == last));
            check("seq.err",   32'(err),       32'd0);
            req_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            req_mask  = NG'($urandom);
        end
        req_valid = 1'b0;
        cur_exp   = mask;
        err_exp   = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst.gate",  32'(gate_en),   32'd0);
        check("rst.busy",  32'(busy),      32'd0);
        check("rst.done",  32'(done),      32'd0);
        check("rst.err",   32'(err),       32'd0);
        check("rst.ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_rst");

        // Directed sequences
        run_req(5'b11111, 1'b0);
        run_req(5'b00101, 1'b0);
        run_req(5'b00011, 1'b0);
        run_req(5'b00011, 1'b1);
        run_req(5'b00011, 1'b0);

        // Random masks with busy-time request noise and idle gaps
        repeat (14) begin
            run_req(NG'($urandom), 1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check_idle("gap");
            end
        end

`ifdef GATE_CTRL_ACK_EN
        // Stuck ack on bit 2: timeout after ACK_TMO cycles, err sticky, bits 3/4 untouched
        begin
            logic [NG-1:0] v;
            int            last;
            run_req(5'b00000, 1'b0);
            ack_ok = 5'b11011;
            last   = 1 + 2 * P + 1 + STEP_DLY + ACK_TMO;
            @(negedge clk);
            check_idle("tmo.pre");
            req_valid = 1'b1;
            req_mask  = 5'b00111;
            v         = '0;
            for (int c = 1; c <= last; c++) begin
                @(negedge clk);
                req_valid = 1'b0;
                if (c == 1)         v[0] = 1'b1;
                if (c == 1 + P)     v[1] = 1'b1;
                if (c == 1 + 2 * P) v[2] = 1'b1;
                check("tmo.gate", 32'(gate_en), 32'(v));
                check("tmo.busy", 32'(busy),    32'd1);
                check("tmo.done", 32'(done),    32'(c == last));
                check("tmo.err",  32'(err),     32'(c == last));
            end
            cur_exp = 5'b00111;
            err_exp = 1'b1;
            ack_ok  = '1;
            @(negedge clk);
            check_idle("tmo.post");
            run_req(5'b00111, 1'b0);
            @(negedge clk);
            check_idle("tmo.clr");
        end
`endif

        // Reset in the middle of the up-sequence, after bit 1 has risen
        run_req(5'b00000, 1'b0);
        @(negedge clk);
        check_idle("mid.pre");
        req_valid = 1'b1;
        req_mask  = 5'b11111;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (P + 2) @(negedge clk);
        check("mid.gate_before", 32'(gate_en), 32'b00011);
        check("mid.busy_before", 32'(busy),    32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid.gate_async",  32'(gate_en),   32'd0);
        check("mid.busy_async",  32'(busy),      32'd0);
        check("mid.done_async",  32'(done),      32'd0);
        check("mid.ready_async", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n   = 1'b1;
        cur_exp = '0;
        err_exp = 1'b0;
        repeat (2 * P) begin
            @(negedge clk);
            check_idle("mid.after");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
